// File: rtl/ddr4_param_controller.sv
// ddr4_param_controller: behavioral DDR4-style controller with per-bank timing, wrapped bursts, refresh and internal storage
module ddr4_param_controller #(
    parameter int BG_W   = 1,
    parameter int BA_W   = 2,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 6,
    parameter int DATA_W = 16,
    parameter int BL     = 4,
    parameter int CL     = 2,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RAS  = 4,
    parameter int T_REFI = 64,
    parameter int T_RFC  = 4
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              CKE,
    input  logic              CS_n,
    input  logic              ACT_n,
    input  logic              WE_n,
    input  logic              PRE_n,
    input  logic              AP,
    input  logic              BURST_MODE,
    input  logic [BG_W-1:0]   BG,
    input  logic [BA_W-1:0]   BA,
    input  logic [ROW_W-1:0]  ROW_ADDRESS,
    input  logic [COL_W-1:0]  COL_ADDRESS,
    input  logic [DATA_W-1:0] DATAIN,
    output logic [DATA_W-1:0] DATAOUT,
    output logic              DATAOUT_VALID,
    output logic              READY,
    output logic              REFRESH_BUSY,
    output logic              ERR
);
    localparam int BK_W = BG_W + BA_W;
    localparam int NB   = 2 ** BK_W;
    localparam int AW   = BK_W + ROW_W + COL_W;
    localparam int TW   = $clog2(T_RCD + T_RP + T_RAS + 1);
    localparam int RW   = $clog2(T_REFI + T_RFC + 1);
    localparam logic [COL_W-1:0] MASK = COL_W'(BL - 1);

    typedef enum logic [1:0] {IDLE, ACTIVATING, ACTIVE, PRECHARGING} bank_t;

    logic [DATA_W-1:0] mem [2**AW];
    bank_t             state [NB];
    bank_t             state_nx [NB];
    logic [TW-1:0]     tmr [NB];
    logic [TW-1:0]     tmr_nx [NB];
    logic [TW-1:0]     ras [NB];
    logic [TW-1:0]     ras_nx [NB];
    logic [ROW_W-1:0]  row [NB];
    logic [ROW_W-1:0]  row_nx [NB];
    logic              ap_pend [NB];
    logic              ap_pend_nx [NB];
    logic              busy, b_we, b_ap;
    logic [BK_W-1:0]   b_bank, bank, iss_bank;
    logic [COL_W-1:0]  b_col, beat, iss_base, iss_k, iss_col;
    logic [AW-1:0]     iss_addr;
    logic [RW-1:0]     refi_cnt, rfc_cnt;
    logic              pend, ref_busy, expire, ref_start;
    logic              accept, is_act, is_pre, is_wr, act_ok, idle_ok, illegal;
    logic              go, rw_go, burst_go, issue, iss_we, last;
    logic              pv [CL];
    logic [DATA_W-1:0] pd [CL];

    // A bank whose activate/precharge timer has run out counts as already settled for the next command
    assign bank      = {BG, BA};
    assign READY     = ~busy & ~ref_busy;
    assign REFRESH_BUSY = ref_busy;
    assign accept    = RESET_n & CKE & ~CS_n & READY;
    assign is_act    = ~ACT_n;
    assign is_pre    = ACT_n & ~PRE_n;
    assign is_wr     = ACT_n & PRE_n & ~WE_n;
    assign act_ok    = state[bank] == ACTIVE || (state[bank] == ACTIVATING && tmr[bank] == '0);
    assign idle_ok   = state[bank] == IDLE || (state[bank] == PRECHARGING && tmr[bank] == '0);
    assign illegal   = is_act ? ~idle_ok :
                       is_pre ? (~act_ok && state[bank] == ACTIVATING) || (act_ok && ras[bank] != '0) :
                       ~act_ok;
    assign go        = accept & ~illegal;
    assign rw_go     = go & ~is_act & ~is_pre;
    assign burst_go  = rw_go & BURST_MODE & (BL > 1);
    assign issue     = rw_go | busy;
    assign iss_we    = busy ? b_we : is_wr;
    assign iss_bank  = busy ? b_bank : bank;
    assign iss_base  = busy ? b_col : COL_ADDRESS;
    assign iss_k     = busy ? beat : '0;
    assign iss_col   = (iss_base & ~MASK) | ((iss_base + iss_k) & MASK);
    assign iss_addr  = {iss_bank, row[iss_bank], iss_col};
    assign last      = busy ? beat == MASK : rw_go & ~burst_go;
    assign expire    = refi_cnt == RW'(T_REFI - 1);
    assign ref_start = (pend | expire) & ~busy & ~accept & ~ref_busy;

    // Per-bank next state: timer expiry, deferred auto-precharge, accepted command, refresh override
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            state_nx[b]   = state[b];
            tmr_nx[b]     = tmr[b] == '0 ? '0 : tmr[b] - 1'b1;
            ras_nx[b]     = ras[b] == '0 ? '0 : ras[b] - 1'b1;
            row_nx[b]     = row[b];
            ap_pend_nx[b] = ap_pend[b];
            if (state[b] == ACTIVATING && tmr[b] == '0) state_nx[b] = ACTIVE;
            if (state[b] == PRECHARGING && tmr[b] == '0) state_nx[b] = IDLE;
            if (ap_pend[b] && state[b] == ACTIVE && ras[b] == '0) begin
                state_nx[b]   = PRECHARGING;
                tmr_nx[b]     = TW'(T_RP - 1);
                ap_pend_nx[b] = 1'b0;
            end
            if (go && BK_W'(b) == bank && is_act) begin
                state_nx[b]   = ACTIVATING;
                tmr_nx[b]     = TW'(T_RCD - 1);
                ras_nx[b]     = TW'(T_RAS - 1);
                row_nx[b]     = ROW_ADDRESS;
                ap_pend_nx[b] = 1'b0;
            end
            if (go && BK_W'(b) == bank && is_pre && act_ok) begin
                state_nx[b]   = PRECHARGING;
                tmr_nx[b]     = TW'(T_RP - 1);
                ap_pend_nx[b] = 1'b0;
            end
            if (issue && last && (busy ? b_ap : AP) && BK_W'(b) == iss_bank) ap_pend_nx[b] = 1'b1;
            if (ref_start) begin
                state_nx[b]   = IDLE;
                tmr_nx[b]     = '0;
                ap_pend_nx[b] = 1'b0;
            end
        end
    end

    // Bank state registers
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int b = 0; b < NB; b++) begin
                state[b]   <= IDLE;
                tmr[b]     <= '0;
                ras[b]     <= '0;
                row[b]     <= '0;
                ap_pend[b] <= 1'b0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                state[b]   <= state_nx[b];
                tmr[b]     <= tmr_nx[b];
                ras[b]     <= ras_nx[b];
                row[b]     <= row_nx[b];
                ap_pend[b] <= ap_pend_nx[b];
            end
        end
    end

    // Burst engine: beat 0 issues on accept, the rest on following cycles
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            busy   <= 1'b0;
            b_we   <= 1'b0;
            b_ap   <= 1'b0;
            b_bank <= '0;
            b_col  <= '0;
            beat   <= '0;
        end else if (burst_go) begin
            busy   <= 1'b1;
            b_we   <= is_wr;
            b_ap   <= AP;
            b_bank <= bank;
            b_col  <= COL_ADDRESS;
            beat   <= COL_W'(1);
        end else if (busy) begin
            beat <= beat + 1'b1;
            busy <= beat != MASK;
        end
    end

    // Refresh interval counter and refresh window
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            refi_cnt <= '0;
            rfc_cnt  <= '0;
            pend     <= 1'b0;
            ref_busy <= 1'b0;
        end else begin
            refi_cnt <= (expire || ref_start) ? '0 : refi_cnt + 1'b1;
            pend     <= ~ref_start & (pend | expire);
            if (ref_start) begin
                ref_busy <= 1'b1;
                rfc_cnt  <= RW'(T_RFC - 1);
            end else if (ref_busy) begin
                ref_busy <= rfc_cnt != '0;
                rfc_cnt  <= rfc_cnt - 1'b1;
            end
        end
    end

    // Storage is deliberately outside reset so contents survive it
    always_ff @(posedge CLK) begin
        if (issue && iss_we) mem[iss_addr] <= DATAIN;
    end

    // Read latency pipeline and registered outputs
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int i = 0; i < CL; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
            DATAOUT       <= '0;
            DATAOUT_VALID <= 1'b0;
            ERR           <= 1'b0;
        end else begin
            pv[0] <= issue & ~iss_we;
            pd[0] <= mem[iss_addr];
            for (int i = 1; i < CL; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            DATAOUT_VALID <= pv[CL-1];
            if (pv[CL-1]) DATAOUT <= pd[CL-1];
            ERR <= accept & illegal;
        end
    end
endmodule

// File: tb/tb_ddr4_param_controller.sv
// tb_ddr4_param_controller: directed self-checking bench for ddr4_param_controller
module tb_ddr4_param_controller;
    logic        CLK, RESET_n, CKE, CS_n, ACT_n, WE_n, PRE_n, AP, BURST_MODE;
    logic [0:0]  BG;
    logic [1:0]  BA;
    logic [7:0]  ROW_ADDRESS;
    logic [5:0]  COL_ADDRESS;
    logic [15:0] DATAIN, DATAOUT;
    logic        DATAOUT_VALID, READY, REFRESH_BUSY, ERR;
    int          checks = 0;
    int          failures = 0;
    int          n;

    ddr4_param_controller dut (
        .CLK(CLK), .RESET_n(RESET_n), .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n), .WE_n(WE_n),
        .PRE_n(PRE_n), .AP(AP), .BURST_MODE(BURST_MODE), .BG(BG), .BA(BA),
        .ROW_ADDRESS(ROW_ADDRESS), .COL_ADDRESS(COL_ADDRESS), .DATAIN(DATAIN),
        .DATAOUT(DATAOUT), .DATAOUT_VALID(DATAOUT_VALID), .READY(READY),
        .REFRESH_BUSY(REFRESH_BUSY), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic act_n, input logic pre_n, input logic we_n, input logic ap,
                       input logic bm, input logic [2:0] bank, input logic [7:0] r,
                       input logic [5:0] c, input logic [15:0] d);
        CS_n = 1'b0;
        ACT_n = act_n;
        PRE_n = pre_n;
        WE_n = we_n;
        AP = ap;
        BURST_MODE = bm;
        {BG, BA} = bank;
        ROW_ADDRESS = r;
        COL_ADDRESS = c;
        DATAIN = d;
        tick();
        CS_n = 1'b1;
        ACT_n = 1'b1;
        PRE_n = 1'b1;
        WE_n = 1'b1;
        AP = 1'b0;
        BURST_MODE = 1'b0;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        tick();
        tick();
        RESET_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        CKE = 1'b1;
        CS_n = 1'b1;
        ACT_n = 1'b1;
        WE_n = 1'b1;
        PRE_n = 1'b1;
        AP = 1'b0;
        BURST_MODE = 1'b0;
        {BG, BA} = '0;
        ROW_ADDRESS = '0;
        COL_ADDRESS = '0;
        DATAIN = '0;
        do_reset();
        check("rst_ready", READY, 1);
        check("rst_valid", DATAOUT_VALID, 0);
        check("rst_err", ERR, 0);
        check("rst_rbusy", REFRESH_BUSY, 0);
        check("rst_dout", DATAOUT, 0);

        cmd(0, 1, 1, 0, 0, 3'd6, 8'h78, 6'h00, 16'h0);
        check("act_err", ERR, 0);
        tick();
        cmd(1, 1, 0, 0, 0, 3'd6, 8'h00, 6'h2C, 16'h72A4);
        check("wr_err", ERR, 0);
        check("wr_single_ready", READY, 1);
        cmd(1, 1, 1, 0, 0, 3'd6, 8'h00, 6'h2C, 16'h0);
        check("rd_lat0", DATAOUT_VALID, 0);
        tick();
        check("rd_lat1", DATAOUT_VALID, 0);
        tick();
        check("rd_valid", DATAOUT_VALID, 1);
        check("rd_data", DATAOUT, 16'h72A4);
        tick();
        check("rd_valid_drop", DATAOUT_VALID, 0);
        check("rd_hold", DATAOUT, 16'h72A4);

        cmd(1, 1, 0, 0, 1, 3'd6, 8'h00, 6'h2E, 16'h7283);
        check("bwr_ready_low", READY, 0);
        DATAIN = 16'h7284;
        tick();
        DATAIN = 16'h7285;
        tick();
        DATAIN = 16'h7286;
        tick();
        check("bwr_ready_back", READY, 1);
        cmd(1, 1, 1, 0, 1, 3'd6, 8'h00, 6'h2C, 16'h0);
        check("brd_ready_low", READY, 0);
        tick();
        check("brd_lat", DATAOUT_VALID, 0);
        tick();
        check("brd_v0", DATAOUT_VALID, 1);
        check("brd_2c", DATAOUT, 16'h7285);
        tick();
        check("brd_2d", DATAOUT, 16'h7286);
        tick();
        check("brd_2e", DATAOUT, 16'h7283);
        tick();
        check("brd_2f", DATAOUT, 16'h7284);
        check("brd_v3", DATAOUT_VALID, 1);
        tick();
        check("brd_end", DATAOUT_VALID, 0);
        CKE = 1'b0;
        cmd(1, 1, 1, 0, 0, 3'd6, 8'h00, 6'h2C, 16'h0);
        CKE = 1'b1;
        tick();
        tick();
        check("cke_ignore", DATAOUT_VALID, 0);

        do_reset();
        cmd(0, 1, 1, 0, 0, 3'd1, 8'h05, 6'h00, 16'h0);
        cmd(1, 1, 1, 0, 0, 3'd1, 8'h00, 6'h00, 16'h0);
        check("rd_early_err", ERR, 1);
        cmd(1, 0, 1, 0, 0, 3'd1, 8'h00, 6'h00, 16'h0);
        check("pre_ras_err", ERR, 1);
        tick();
        check("rd_early_novalid", DATAOUT_VALID, 0);
        check("err_pulse", ERR, 0);
        cmd(1, 1, 1, 0, 0, 3'd1, 8'h00, 6'h00, 16'h0);
        check("still_active", ERR, 0);
        tick();
        tick();
        check("still_active_rd", DATAOUT_VALID, 1);
        cmd(1, 0, 1, 0, 0, 3'd1, 8'h00, 6'h00, 16'h0);
        check("pre_ok", ERR, 0);
        cmd(1, 1, 1, 0, 0, 3'd1, 8'h00, 6'h00, 16'h0);
        check("rd_precharging_err", ERR, 1);

        do_reset();
        cmd(0, 1, 1, 0, 0, 3'd2, 8'h11, 6'h00, 16'h0);
        tick();
        cmd(1, 1, 0, 1, 0, 3'd2, 8'h00, 6'h00, 16'h1234);
        check("ap_wr_err", ERR, 0);
        check("ap_ready", READY, 1);
        tick();
        tick();
        cmd(0, 1, 1, 0, 0, 3'd2, 8'h11, 6'h00, 16'h0);
        check("ap_deferred", ERR, 1);
        cmd(0, 1, 1, 0, 0, 3'd2, 8'h11, 6'h00, 16'h0);
        check("ap_trp_act", ERR, 0);
        tick();
        cmd(1, 1, 1, 0, 0, 3'd2, 8'h00, 6'h00, 16'h0);
        tick();
        tick();
        check("ap_rd_valid", DATAOUT_VALID, 1);
        check("ap_rd_data", DATAOUT, 16'h1234);

        do_reset();
        cmd(0, 1, 1, 0, 0, 3'd3, 8'h22, 6'h00, 16'h0);
        n = 1;
        while (!REFRESH_BUSY && n < 200) begin
            tick();
            n++;
        end
        check("refi_start", n, 64);
        check("rf_ready", READY, 0);
        cmd(1, 1, 1, 0, 0, 3'd3, 8'h00, 6'h00, 16'h0);
        check("rf_busy1", REFRESH_BUSY, 1);
        tick();
        check("rf_busy2", REFRESH_BUSY, 1);
        tick();
        check("rf_busy3", REFRESH_BUSY, 1);
        check("rf_rd_ignored", DATAOUT_VALID, 0);
        check("rf_rd_noerr", ERR, 0);
        tick();
        check("rf_done", REFRESH_BUSY, 0);
        check("rf_ready_back", READY, 1);
        cmd(0, 1, 1, 0, 0, 3'd3, 8'h22, 6'h00, 16'h0);
        check("rf_bank_idle", ERR, 0);

        do_reset();
        cmd(0, 1, 1, 0, 0, 3'd6, 8'h78, 6'h00, 16'h0);
        tick();
        cmd(1, 1, 1, 0, 1, 3'd6, 8'h00, 6'h2C, 16'h0);
        tick();
        tick();
        check("pre_rst_valid", DATAOUT_VALID, 1);
        check("pre_rst_data", DATAOUT, 16'h7285);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_valid", DATAOUT_VALID, 0);
        check("mid_rst_dout", DATAOUT, 0);
        check("mid_rst_ready", READY, 1);
        check("mid_rst_err", ERR, 0);
        tick();
        RESET_n = 1'b1;
        tick();
        check("post_rst_ready", READY, 1);
        check("post_rst_valid1", DATAOUT_VALID, 0);
        tick();
        check("post_rst_valid2", DATAOUT_VALID, 0);
        cmd(0, 1, 1, 0, 0, 3'd6, 8'h78, 6'h00, 16'h0);
        tick();
        cmd(1, 1, 1, 0, 0, 3'd6, 8'h00, 6'h2D, 16'h0);
        tick();
        tick();
        check("retain_valid", DATAOUT_VALID, 1);
        check("retain_data", DATAOUT, 16'h7286);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr4_param_controller.md
DDR4_PARAM_CONTROLLER -- requirements
Module: ddr4_param_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  BG_W 1 bank-group address bits; BA_W 2 bank address bits; ROW_W 8 row bits; COL_W 6 column bits; DATA_W 16 data width.
  BL 4 burst length (power of 2, <= 2**COL_W); CL 2 read latency in cycles (>=1).
  T_RCD 2; T_RP 2; T_RAS 4; T_REFI 64; T_RFC 4 (all in cycles, >=1).
REQ-002 One clock; reset is asynchronous and active-low. Ports, one per line: name direction width meaning.
  CLK in 1 clock, rising edge.
  RESET_n in 1 async active-low reset.
  CKE in 1 clock enable; 0 suppresses command decode.
  CS_n in 1 chip select, active low.
  ACT_n in 1 activate, active low.
  WE_n in 1 0 = write, 1 = read.
  PRE_n in 1 precharge, active low.
  AP in 1 auto-precharge with read/write.
  BURST_MODE in 1 1 = BL beats, 0 = single beat.
  BG in BG_W bank group.
  BA in BA_W bank.
  ROW_ADDRESS in ROW_W row.
  COL_ADDRESS in COL_W column.
  DATAIN in DATA_W write data.
  DATAOUT out DATA_W read data.
  DATAOUT_VALID out 1 DATAOUT qualifier.
  READY out 1 command accept window.
  REFRESH_BUSY out 1 refresh in progress.
  ERR out 1 one-cycle illegal-command pulse.

Function
REQ-003 Storage: 2**(BG_W+BA_W+ROW_W+COL_W) words of DATA_W, indexed {BG,BA,row,col}; NB = 2**(BG_W+BA_W) banks.
REQ-004 Command accepted on a rising edge only when CKE=1, CS_n=0 and READY=1; otherwise ignored, no state change.
REQ-005 Decode priority: ACT_n=0 -> ACTIVATE; else PRE_n=0 -> PRECHARGE; else WE_n=0 -> WRITE; else READ; AP qualifies WRITE/READ only.
REQ-006 Per-bank FSM: IDLE -ACT-> ACTIVATING (T_RCD cycles) -> ACTIVE -PRE-> PRECHARGING (T_RP cycles) -> IDLE; open row latched on ACT.
REQ-007 Per-bank tRAS counter starts on ACT; precharge (explicit or auto) shall not begin before T_RAS cycles after ACT.
REQ-008 ERR pulses and the command is dropped for: ACT to non-IDLE bank; READ/WRITE to non-ACTIVE bank; PRE to ACTIVATING bank or before tRAS met. PRE to IDLE bank is a legal no-op.
REQ-009 WRITE: beat 0 DATAIN captured on accept cycle; beats 1..BL-1 on following consecutive cycles.
REQ-010 READ: beat k drives DATAOUT with DATAOUT_VALID=1 exactly CL+k cycles after accept.
REQ-011 Burst column = {COL_ADDRESS[COL_W-1:log2 BL], (COL_ADDRESS[log2 BL-1:0]+k) mod BL}: wraps inside BL-aligned block, never crosses it.
REQ-012 READY=0 while a write or read burst is transferring (accept through last beat issue) and while REFRESH_BUSY=1; single-beat commands do not drop READY.
REQ-013 AP=1: bank enters PRECHARGING on the cycle after the last beat, deferred until tRAS met; READY unaffected.
REQ-014 Refresh counter counts T_REFI cycles, independent of CKE; on expiry refresh is pending, waits for no active burst, then all banks forced to IDLE, REFRESH_BUSY=1, READY=0 for T_RFC cycles; counter reloads at refresh start.
REQ-015 Command accept and refresh expiry in the same cycle: command accepted, refresh starts after its burst.
REQ-016 DATAOUT holds last value when DATAOUT_VALID=0; ERR and DATAOUT_VALID are registered outputs.

Reset
REQ-017 RESET_n=0 at any time, including mid-burst or mid-refresh: all banks IDLE, counters cleared, pending bursts/reads discarded, DATAOUT=0, DATAOUT_VALID=0, ERR=0, REFRESH_BUSY=0, READY=1 from first clock after deassertion.
REQ-018 Storage contents are retained across reset.

Verification
REQ-019 ACT row 8'h78 BG1 BA2; after T_RCD, WRITE col 6'h2C data 16'h72A4 single; READ col 6'h2C -> DATAOUT=16'h72A4, VALID exactly CL cycles after READ.
REQ-020 BURST_MODE=1 WRITE col 6'h2E data 16'h7283..7286; READ col 6'h2C burst -> beats in column order 2C,2D,2E,2F with 2E/2F = 16'h7283/7284 (wrap check).
REQ-021 READ 1 cycle after ACT (T_RCD=2) -> ERR pulse, no DATAOUT_VALID; PRE 2 cycles after ACT (T_RAS=4) -> ERR, bank stays ACTIVE.
REQ-022 WRITE with AP=1 1 cycle after ACTIVE -> precharge deferred to tRAS, ACT same bank accepted exactly T_RP cycles after precharge start.
REQ-023 Run 64 cycles idle -> REFRESH_BUSY high 4 cycles, READY low, all banks IDLE; READ issued during -> ignored.
REQ-024 Assert RESET_n=0 during burst beat 2 -> outputs per REQ-017 immediately; prior stored data readable after re-ACT.
